// File: rtl/lim_cnt_chain.sv
// ---------------------------------------------------------------------------
// lim_cnt_chain
//   Cascade of DIGITS modulo-limited digit counters for the stopwatch time
//   base (default limits 6/10/6/10 give mm:ss). Digit 0 is least significant.
//   Each digit i counts 0..LIMITS[8*i+7:8*i]-1. The counter can count up or
//   down, load in parallel and clear synchronously, and it reports terminal
//   count and wrap.
//
//   Optional build macro LIM_CNT_SAT_EN selects saturating mode. A tick that
//   would carry or borrow out of the top digit leaves count unchanged and
//   sets the sticky sat output. Reset, clr and load clear sat. The sat port
//   exists only when the macro is defined.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active low
//   tick      in   count enable; one step per cycle while high
//   up_dn     in   1 = count up, 0 = count down
//   clr       in   synchronous clear (priority over load and tick)
//   load      in   synchronous parallel load (priority over tick)
//   load_val  in   packed digits to load, digit i at [W*i +: W]
//   count     out  registered counter value, same packing as load_val
//   tc        out  terminal count from current count and up_dn
//                  (up: every digit at limit-1, down: every digit zero)
//   wrap      out  one-cycle pulse aligned with a wrapped count
//   sat       out  sticky saturation flag (LIM_CNT_SAT_EN only)
// ---------------------------------------------------------------------------
module lim_cnt_chain #(
    parameter int                  DIGITS = 4,
    parameter int                  W      = 4,
    parameter logic [8*DIGITS-1:0] LIMITS = 32'h060A_060A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DIGITS*W-1:0]   load_val,
    output logic [DIGITS*W-1:0]   count,
    output logic                  tc,
    output logic                  wrap
`ifdef LIM_CNT_SAT_EN
    ,
    output logic                  sat
`endif
);

    // Limit of digit i, widened by one bit so that a limit of 2**W fits.
    function automatic logic [W:0] lim_of(input int i);
        return (W+1)'(LIMITS[8*i +: 8]);
    endfunction

    // One up-counting digit. Returns {carry_out, next_digit}.
    // An out-of-range digit always wraps to 0 and carries, whatever the
    // carry-in is, so invalid loaded values clear on the first tick.
    function automatic logic [W:0] dig_inc(input logic [W-1:0] d,
                                           input logic         c,
                                           input logic [W:0]   lim);
        logic [W:0] dx;
        logic [W:0] sum;
        dx  = {1'b0, d};
        sum = dx + (W+1)'(c);
        if (dx >= lim)
            return {1'b1, {W{1'b0}}};
        else if (sum == lim)
            return {1'b1, {W{1'b0}}};
        else
            return {1'b0, W'(sum)};
    endfunction

    // One down-counting digit. Returns {borrow_out, next_digit}.
    // An out-of-range digit always becomes limit-1 and borrows.
    function automatic logic [W:0] dig_dec(input logic [W-1:0] d,
                                           input logic         b,
                                           input logic [W:0]   lim);
        logic [W:0] dx;
        dx = {1'b0, d};
        if (dx >= lim)
            return {1'b1, W'(lim - (W+1)'(1))};
        else if ((d == '0) && b)
            return {1'b1, W'(lim - (W+1)'(1))};
        else
            return {1'b0, d - W'(b)};
    endfunction

    logic [DIGITS*W-1:0] cnt_p1;
    logic                wrap_p1;
    logic [DIGITS*W-1:0] nxt_p0;
    logic                top_out_p0;

    // ---- stage p0: combinational carry/borrow ripple across the digits ----
    always_comb begin
        logic       c;
        logic [W:0] r;
        c      = 1'b1;
        r      = '0;
        nxt_p0 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (up_dn)
                r = dig_inc(cnt_p1[W*i +: W], c, lim_of(i));
            else
                r = dig_dec(cnt_p1[W*i +: W], c, lim_of(i));
            nxt_p0[W*i +: W] = r[W-1:0];
            c                = r[W];
        end
        top_out_p0 = c;
    end

    // Terminal count looks only at the registered value and the direction.
    always_comb begin
        logic all_top;
        all_top = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, cnt_p1[W*i +: W]} != lim_of(i) - (W+1)'(1))
                all_top = 1'b0;
        end
        tc = up_dn ? all_top : (cnt_p1 == '0);
    end

    // ---- stage p1: registered count, wrap pulse (and sticky sat) ----
`ifdef LIM_CNT_SAT_EN
    logic sat_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1  <= '0;
            wrap_p1 <= 1'b0;
            sat_p1  <= 1'b0;
        end else if (clr) begin
            cnt_p1  <= '0;
            wrap_p1 <= 1'b0;
            sat_p1  <= 1'b0;
        end else if (load) begin
            cnt_p1  <= load_val;
            wrap_p1 <= 1'b0;
            sat_p1  <= 1'b0;
        end else if (tick) begin
            // A step that would leave the top digit is refused outright.
            if (top_out_p0) begin
                sat_p1 <= 1'b1;
            end else begin
                cnt_p1 <= nxt_p0;
            end
            wrap_p1 <= 1'b0;
        end else begin
            wrap_p1 <= 1'b0;
        end
    end

    assign sat = sat_p1;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1  <= '0;
            wrap_p1 <= 1'b0;
        end else if (clr) begin
            cnt_p1  <= '0;
            wrap_p1 <= 1'b0;
        end else if (load) begin
            cnt_p1  <= load_val;
            wrap_p1 <= 1'b0;
        end else if (tick) begin
            cnt_p1  <= nxt_p0;
            wrap_p1 <= top_out_p0;
        end else begin
            wrap_p1 <= 1'b0;
        end
    end
`endif

    assign count = cnt_p1;
    assign wrap  = wrap_p1;

endmodule

// File: tb/tb_lim_cnt_chain.sv
// ---------------------------------------------------------------------------
// tb_lim_cnt_chain
//   Self-checking bench for lim_cnt_chain at default parameters (modulo
//   build). Every driven cycle pushes the predicted {count, wrap, tc} into a
//   scoreboard queue; a monitor pops and compares one entry per rising edge.
//   Directed steps also compare against literal values.
// ---------------------------------------------------------------------------
module tb_lim_cnt_chain;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        tc;
    logic        wrap;

    int n_chk;
    int n_bad;

    typedef struct {
        logic [15:0] cnt;
        logic        wrap;
        logic        tc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Reference state
    logic [15:0] m_cnt;
    logic        m_wrap;
    logic        m_tc;
    int          lim[4] = '{10, 6, 10, 6};

    lim_cnt_chain #(
        .DIGITS (4),
        .W      (4),
        .LIMITS (32'h060A_060A)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit c_clr, input bit c_ld,
                              input logic [15:0] lv,
                              input bit c_tk, input bit c_up);
        int d;
        int c;
        if (c_clr) begin
            m_cnt  = '0;
            m_wrap = 1'b0;
        end else if (c_ld) begin
            m_cnt  = lv;
            m_wrap = 1'b0;
        end else if (c_tk) begin
            c = 1;
            for (int i = 0; i < 4; i++) begin
                d = int'(m_cnt[4*i +: 4]);
                if (c_up) begin
                    if (d >= lim[i])          begin d = 0;          c = 1; end
                    else if (d + c == lim[i]) begin d = 0;          c = 1; end
                    else                      begin d = d + c;      c = 0; end
                end else begin
                    if (d >= lim[i])            begin d = lim[i] - 1; c = 1; end
                    else if (d == 0 && c == 1)  begin d = lim[i] - 1; c = 1; end
                    else                        begin d = d - c;      c = 0; end
                end
                m_cnt[4*i +: 4] = d[3:0];
            end
            m_wrap = (c != 0);
        end else begin
            m_wrap = 1'b0;
        end
        if (c_up) begin
            m_tc = 1'b1;
            for (int i = 0; i < 4; i++)
                if (int'(m_cnt[4*i +: 4]) != lim[i] - 1) m_tc = 1'b0;
        end else begin
            m_tc = (m_cnt == 16'h0000);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the prediction.
    task automatic drive(input bit c_clr, input bit c_ld, input logic [15:0] lv,
                         input bit c_tk, input bit c_up);
        exp_t e;
        @(negedge clk);
        clr      = c_clr;
        load     = c_ld;
        load_val = lv;
        tick     = c_tk;
        up_dn    = c_up;
        model_step(c_clr, c_ld, lv, c_tk, c_up);
        e.cnt  = m_cnt;
        e.wrap = m_wrap;
        e.tc   = m_tc;
        sbq.push_back(e);
    endtask

    // Literal check right after the edge that follows a drive().
    task automatic tp(input string tag, input logic [15:0] c, input logic w);
        @(posedge clk);
        #2;
        chk({tag, "_cnt"}, count, c);
        chk({tag, "_wrap"}, wrap, w);
    endtask

    task automatic idle_inputs();
        clr  = 1'b0;
        load = 1'b0;
        tick = 1'b0;
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("sb_cnt", count, mon_e.cnt);
            chk("sb_wrap", wrap, mon_e.wrap);
            chk("sb_tc", tc, mon_e.tc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        tick     = 1'b0;
        up_dn    = 1'b0;
        load_val = '0;
        m_cnt    = '0;
        m_wrap   = 1'b0;
        m_tc     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", count, 16'h0000);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_tc_dn", tc, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // 09:59 up -> 10:00, and back down
        drive(0, 1, 16'h0959, 0, 1);
        tp("ld0959", 16'h0959, 1'b0);
        drive(0, 0, 16'h0000, 1, 1);
        tp("up0959", 16'h1000, 1'b0);
        drive(0, 0, 16'h0000, 1, 0);
        tp("dn1000", 16'h0959, 1'b0);

        // 59:59 terminal count up, wrap pulse lasts one cycle
        drive(0, 1, 16'h5959, 0, 1);
        tp("ld5959", 16'h5959, 1'b0);
        chk("tc_up5959", tc, 1'b1);
        drive(0, 0, 16'h0000, 1, 1);
        tp("wrap_up", 16'h0000, 1'b1);
        drive(0, 0, 16'h0000, 0, 1);
        tp("wrap_end", 16'h0000, 1'b0);
        chk("tc_up0000", tc, 1'b0);

        // 00:00 down wraps to 59:59, then 100 more seconds down
        drive(0, 1, 16'h0000, 0, 0);
        tp("ld0000", 16'h0000, 1'b0);
        chk("tc_dn0000", tc, 1'b1);
        drive(0, 0, 16'h0000, 1, 0);
        tp("wrap_dn", 16'h5959, 1'b1);
        for (int i = 0; i < 100; i++)
            drive(0, 0, 16'h0000, 1, 0);
        tp("dn100", 16'h5819, 1'b0);

        // Invalid digit holds without tick, corrected on tick
        drive(0, 1, 16'h00C0, 0, 1);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 16'h0000, 0, 1);
        tp("hold00C0", 16'h00C0, 1'b0);
        drive(0, 0, 16'h0000, 1, 1);
        tp("fix00C0", 16'h0101, 1'b0);

        // Priority: clr > load > tick
        drive(0, 1, 16'h0505, 0, 1);
        drive(1, 1, 16'h1234, 1, 1);
        tp("clr_pri", 16'h0000, 1'b0);
        drive(0, 1, 16'h1234, 1, 1);
        tp("ld_pri", 16'h1234, 1'b0);

        // Asynchronous reset mid-count at 03:47
        drive(0, 1, 16'h0340, 0, 1);
        for (int i = 0; i < 7; i++)
            drive(0, 0, 16'h0000, 1, 1);
        tp("cnt0347", 16'h0347, 1'b0);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", count, 16'h0000);
        chk("arst_wrap", wrap, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_cnt  = '0;
        m_wrap = 1'b0;

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            automatic int  r  = $urandom_range(0, 99);
            automatic bit  rc = (r < 3);
            automatic bit  rl = (r >= 3 && r < 12);
            automatic bit  rt = ($urandom_range(0, 9) < 8);
            automatic bit  ru = ($urandom_range(0, 3) != 0);
            automatic logic [15:0] rv = 16'($urandom_range(0, 65535));
            drive(rc, rl, rv, rt, ru);
        end
        drive(0, 0, 16'h0000, 0, 1);
        @(posedge clk);
        #3;
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
